// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional misalignment checking in fetch_unit is enabled by FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two synchronous FIFO with clear and a combinational head read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           clear,
  input  logic           push,
  input  fetch_entry_t   push_data,
  input  logic           pop,
  output fetch_entry_t   head,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t        mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;

  // Pointer and occupancy bookkeeping; clear drops every buffered entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding memory requests, prefetch FIFO.
// Define FETCH_MISALIGN_CHK_EN to add the sticky misalign_o check on redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        flush_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_r, state_nxt_s;
  logic [31:0]   pc_r;
  logic [31:0]   addr_r;
  logic [31:0]   target_s;
  logic          halt_s;
  logic          credit_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_r;

  // Sticky flag for a redirect to a non-word-aligned target; halts fetching until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misalign_r <= 1'b0;
    end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
      misalign_r <= 1'b1;
    end
  end

  assign misalign_o = misalign_r;
  assign halt_s     = misalign_r;
  assign target_s   = redirect_pc_i;
`else
  assign halt_s     = 1'b0;
  assign target_s   = word_align(redirect_pc_i);
`endif

  assign credit_s    = ((CW'(FIFO_DEPTH) - fifo_count_s) != '0);
  assign push_data_s = '{instr: imem_rdata_i, pc_plus4: addr_r + 32'd4};

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next state, issue and push decisions; redirect overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rst_n_i && credit_s && !redirect_i && !halt_s) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (imem_ack_i) begin
          push_s      = !redirect_i && (!fifo_full_s || pop_s);
          state_nxt_s = ST_IDLE;
        end else if (redirect_i) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_ack_i) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DROP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Fetch PC and the address of the request currently in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_r   <= RESET_PC;
      addr_r <= RESET_PC;
    end else if (redirect_i) begin
      pc_r   <= target_s;
    end else if (issue_s) begin
      pc_r   <= pc_r + 32'd4;
      addr_r <= pc_r;
    end
  end

  assign pop_s = !fifo_empty_s && !stall_i && !redirect_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear     (redirect_i),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign imem_req_o  = issue_s;
  assign imem_addr_o = (state_r == ST_IDLE) ? pc_r : addr_r;
  assign valid_o     = !fifo_empty_s;
  assign instr_o     = fifo_empty_s ? NOP_INSTR : head_s.instr;
  assign pc_plus4_o  = fifo_empty_s ? 32'd0 : head_s.pc_plus4;
  assign flush_o     = redirect_i | (~valid_o & ~stall_i);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that produces the instruction and PC+4 pair consumed by the IF/ID pipeline register. It owns the program counter, issues single-outstanding requests to instruction memory, and buffers returned words in a small prefetch FIFO. It honours the hazard-detection stall and branch redirects, and emits flush bubbles when no instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `FIFO_DEPTH`, 2, prefetch buffer entries; must be a power of two and ≥2.
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `stall_i` in 1: hazard-detection stall; the FIFO head is held and not popped.
- `redirect_i` in 1: taken branch or jump; kills all fetched and in-flight words.
- `redirect_pc_i` in 32: new fetch address, sampled when `redirect_i`=1.
- `imem_req_o` out 1: memory request valid.
- `imem_addr_o` out 32: request address; stable while `imem_req_o`=1 until ack.
- `imem_ack_i` in 1: response valid, at least one cycle after the request.
- `imem_rdata_i` in 32: instruction word, valid with `imem_ack_i`.
- `instr_o` out 32: FIFO head instruction; 32'b0 when empty.
- `pc_plus4_o` out 32: FIFO head PC+4; 32'b0 when empty.
- `valid_o` out 1: FIFO head valid.
- `flush_o` out 1: drives the IF/ID flush input; equals `redirect_i | (~valid_o & ~stall_i)`.

## Operation
- PC register `pc_q`: reset to `RESET_PC`. Advances by 4 (mod 2^32, wraps silently) each time a request is issued.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its data will be kept.
  - DROP: request outstanding; its data will be discarded.
- Issue condition (IDLE only): `credits = FIFO_DEPTH - count > 0` and `~redirect_i`. When true, `imem_req_o`=1 and `imem_addr_o`=`pc_q`, both combinational from registered state. Transition to WAIT.
- WAIT, `imem_ack_i`=1: push {`imem_rdata_i`, addr+4} into the FIFO and go to IDLE.
- DROP, `imem_ack_i`=1: discard the data and go to IDLE.
- Pop: FIFO not empty and `~stall_i` and `~redirect_i`.
- Redirect, which has highest priority:
  - Clear the FIFO and set `pc_q <= redirect_pc_i`.
  - WAIT without ack → DROP.
  - WAIT with a same-cycle ack → IDLE, ack data discarded.
  - IDLE: no request issued that cycle.
  - DROP stays DROP unless acked.
- Simultaneous push and pop while full is legal: count is unchanged. A push never occurs when full, because credits forbid issue.
- Stall and redirect together: the redirect wins and `flush_o`=1.

## Timing
- Reset values: `pc_q`=`RESET_PC`, state IDLE, FIFO empty, `imem_req_o`=0 during reset, `valid_o`=0, `instr_o`=0, `pc_plus4_o`=0, `flush_o`=1.
- The first request is issued in the first cycle after `rst_n_i` deasserts.
- Ack in cycle N → `valid_o`=1 in cycle N+1 → IF/ID captures at the end of N+1.
- With a 1-cycle memory, sustained throughput is one instruction per 2 cycles. FIFO_DEPTH ≥2 hides stalls of up to FIFO_DEPTH cycles.
- Redirect in cycle N → new-target request in N+1 if IDLE, otherwise the cycle after the dropped ack.
- Reset asserted mid-request: the state machine returns to IDLE immediately. A later stray ack in IDLE is ignored.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - Adds output `misalign_o` (1 bit, resets to 0).
  - A redirect with `redirect_pc_i[1:0]`≠0 sets `misalign_o` sticky until reset.
  - While `misalign_o`=1, no further requests are issued.
- `FETCH_MISALIGN_CHK_EN` undefined: the port is absent and `redirect_pc_i[1:0]` is forced to 2'b00.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE/WAIT/DROP);
  - `NOP_INSTR` = 32'h0;
  - the default `RESET_PC`;
  - the FIFO entry struct {instr, pc_plus4}.
- Sub-module `fetch_fifo`: a parameterised synchronous FIFO with push/pop/clear, full/empty/count, and a combinational head read. `fetch_unit` instantiates it once.

## Test plan
- Reset release, memory acks after 1 cycle with data 32'h0000_0013 → request addr 0x0 in cycle 0; `valid_o`=1, `instr_o`=0x13, `pc_plus4_o`=0x4 in cycle 2.
- Hold `stall_i` for 5 cycles with a 1-cycle memory → FIFO fills to 2, `imem_req_o` stays low, head is unchanged. On release, the entries pop in order 0x4, 0x8.
- Assert `redirect_i` with target 0x100 while a request to 0x8 is outstanding → ack data dropped; next request addr 0x100; `flush_o`=1 in the redirect cycle.
- Redirect in the same cycle as an ack → ack data never appears on `instr_o`; next request is 0x100.
- Memory withholds ack for 4 cycles → `valid_o`=0 and `flush_o`=1 every non-stalled cycle; `imem_addr_o` stays stable.
- Macro defined, redirect to 0x102 → `misalign_o`=1 next cycle, no further requests; reset clears it.
